// File: rtl/lsq_mem_queue_pkg.sv
// lsq_mem_queue_pkg: LC-3b shared types (word, ROB id, CDB, LSQ op/entry/state) for the load/store queue.
`ifndef NUM_LSQ_ENTRIES
`define NUM_LSQ_ENTRIES 8
`endif
package lsq_mem_queue_pkg;
  localparam int LSQ_DEPTH = `NUM_LSQ_ENTRIES;
  typedef logic [15:0] lc3b_word;
  typedef logic [3:0] lc3b_rob_id;
  typedef enum logic [1:0] {LSQ_LDW, LSQ_LDB, LSQ_STW, LSQ_STB} lc3b_lsq_op;
  typedef struct packed {
    lc3b_rob_id dest;
    lc3b_word   value;
    logic       update_pc;
    lc3b_word   update_pc_value;
    logic       ready;
  } lc3b_cdb;
  typedef struct packed {
    logic       valid;
    lc3b_lsq_op op;
    lc3b_rob_id dest;
    lc3b_word   addr;
    logic       addr_v;
    lc3b_word   data;
    logic       data_v;
    lc3b_rob_id data_tag;
    logic       committed;
  } lc3b_lsq_entry;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STORE, S_WAIT_CDB, S_DROP} lsq_state_e;
  function automatic logic is_store(input lc3b_lsq_op op);
    return op == LSQ_STW || op == LSQ_STB;
  endfunction
endpackage

// File: rtl/lsq_mem_queue_format.sv
// lsq_mem_format: word/byte address alignment, byte enables, store-data replication and LDB sign extension.
module lsq_mem_format
  import lsq_mem_queue_pkg::*;
(
  input  lc3b_lsq_op  i_op,
  input  lc3b_word    i_addr,
  input  lc3b_word    i_data,
  input  lc3b_word    i_rdata,
  output lc3b_word    o_address,
  output lc3b_word    o_wdata,
  output lc3b_word    o_ld_result,
  output logic [1:0]  o_be
);
  logic       w_byte;
  logic [7:0] w_rbyte;
  always_comb begin
    w_byte = i_op == LSQ_LDB || i_op == LSQ_STB;
    w_rbyte = i_addr[0] ? i_rdata[15:8] : i_rdata[7:0];
    o_address = i_addr & 16'hFFFE;
    o_be = w_byte ? (i_addr[0] ? 2'b10 : 2'b01) : 2'b11;
    o_wdata = i_op == LSQ_STB ? {2{i_data[7:0]}} : i_data;
    o_ld_result = i_op == LSQ_LDB ? {{8{w_rbyte[7]}}, w_rbyte} : i_rdata;
  end
endmodule

// File: rtl/lsq_mem_queue.sv
// lsq_mem_queue: in-order LC-3b load/store queue issuing one access at a time from the head.
// Define LSQ_STATS_EN to add saturating stat_loads/stat_stores/stat_stall counters.
module lsq_mem_queue
  import lsq_mem_queue_pkg::*;
#(
  parameter int DEPTH = LSQ_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_lsq,
  input  lc3b_lsq_op  op_in,
  input  lc3b_rob_id  dest_in,
  input  lc3b_word    vk_in,
  input  lc3b_rob_id  qk_in,
  input  logic        data_ready_in,
  output logic        lsq_available,
  input  lc3b_cdb     agu_bus,
  input  lc3b_cdb     data_bus,
  output lc3b_cdb     data_bus_out,
  output logic        cdb_req,
  input  logic        cdb_grant,
  input  logic        rob_commit,
  input  lc3b_rob_id  rob_commit_pos,
  input  logic        flush,
  output lc3b_word    mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output lc3b_word    mem_wdata,
  output logic [1:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  lc3b_word    mem_rdata
`ifdef LSQ_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_stall
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  lc3b_lsq_entry  r_q [DEPTH];
  lc3b_lsq_entry  r_drop, w_head, w_cur;
  logic [AW-1:0]  r_head, r_tail;
  logic [CW-1:0]  r_count, w_keep;
  lsq_state_e     r_state, w_next;
  lc3b_word       r_result, w_addr, w_wdata, w_ld_result;
  lc3b_cdb        w_drive;
  logic [1:0]     w_be;
  logic           w_ld_go, w_st_go, w_in_load, w_in_store, w_alloc, w_pop, w_ld_pop, w_run, w_unused;

  assign w_head = r_q[r_head];
  // a dropped load keeps presenting its own address even if the slot is reallocated
  assign w_cur = r_state == S_DROP ? r_drop : w_head;
  assign lsq_available = r_count < CW'(DEPTH);
  assign w_alloc = ld_lsq && lsq_available && !flush;
  assign w_unused = ^{agu_bus, data_bus, w_cur};

  lsq_mem_format u_fmt (
    .i_op(w_cur.op), .i_addr(w_cur.addr), .i_data(w_cur.data), .i_rdata(mem_rdata),
    .o_address(w_addr), .o_wdata(w_wdata), .o_ld_result(w_ld_result), .o_be(w_be)
  );

  always_comb begin
    w_ld_go = r_state == S_IDLE && w_head.valid && !is_store(w_head.op) && w_head.addr_v && !flush;
    w_st_go = r_state == S_IDLE && w_head.valid && is_store(w_head.op) && w_head.addr_v && w_head.data_v && w_head.committed;
    w_in_load = w_ld_go || r_state == S_LOAD;
    w_in_store = w_st_go || r_state == S_STORE;
    cdb_req = r_state == S_WAIT_CDB && !flush;
    w_ld_pop = cdb_req && cdb_grant;
    w_pop = w_ld_pop || (w_in_store && mem_resp);
    mem_read = w_in_load || r_state == S_DROP;
    mem_write = w_in_store;
    w_next = r_state;
    if (w_in_load) w_next = flush ? (mem_resp ? S_IDLE : S_DROP) : (mem_resp ? S_WAIT_CDB : S_LOAD);
    else if (w_in_store) w_next = mem_resp ? S_IDLE : S_STORE;
    else if (r_state == S_DROP) w_next = mem_resp ? S_IDLE : S_DROP;
    else if (r_state == S_WAIT_CDB && (flush || cdb_grant)) w_next = S_IDLE;
  end

  // length of the committed run starting at the head; a flush retracts the tail to it
  always_comb begin
    w_keep = '0;
    w_run = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      w_run = w_run && CW'(i) < r_count && r_q[r_head + AW'(i)].committed;
      w_keep = w_keep + CW'(w_run);
    end
  end

  always_comb begin
    w_drive = '0;
    w_drive.dest = w_head.dest;
    w_drive.value = r_result;
  end

  assign data_bus_out = w_ld_pop ? w_drive : 'z;
  assign mem_address = mem_read || mem_write ? w_addr : '0;
  assign mem_byte_enable = mem_read || mem_write ? w_be : '0;
  assign mem_wdata = mem_write ? w_wdata : '0;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_drop <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_state <= S_IDLE;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_in_load && mem_resp) r_result <= w_ld_result;
      if (w_in_load && flush) r_drop <= w_head;
      for (int i = 0; i < DEPTH; i++) begin
        if (r_q[i].valid && !r_q[i].addr_v && agu_bus.dest != '0 && r_q[i].dest == agu_bus.dest) begin
          r_q[i].addr <= agu_bus.value;
          r_q[i].addr_v <= 1'b1;
        end
        if (r_q[i].valid && is_store(r_q[i].op) && !r_q[i].data_v && r_q[i].data_tag == data_bus.dest) begin
          r_q[i].data <= data_bus.value;
          r_q[i].data_v <= 1'b1;
        end
        if (r_q[i].valid && rob_commit && r_q[i].dest == rob_commit_pos) r_q[i].committed <= 1'b1;
        if (flush && !r_q[i].committed) r_q[i].valid <= 1'b0;
      end
      if (w_pop) r_q[r_head].valid <= 1'b0;
      if (w_alloc)
        r_q[r_tail] <= '{valid: 1'b1, op: op_in, dest: dest_in, addr: 16'h0000, addr_v: 1'b0,
                         data: vk_in, data_v: data_ready_in, data_tag: qk_in, committed: 1'b0};
      r_head <= r_head + AW'(w_pop);
      r_tail <= flush ? r_head + w_keep[AW-1:0] : r_tail + AW'(w_alloc);
      r_count <= flush ? w_keep - CW'(w_pop) : r_count + CW'(w_alloc) - CW'(w_pop);
    end

`ifdef LSQ_STATS_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stat_loads <= '0;
      stat_stores <= '0;
      stat_stall <= '0;
    end else begin
      if (w_ld_pop && stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
      if (w_in_store && mem_resp && stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
      if (r_state == S_IDLE && w_head.valid && !w_ld_go && !w_st_go && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
`endif
endmodule

// File: tb/tb_lsq_mem_queue.sv
// tb_lsq_mem_queue: table-driven cycle vectors plus directed full-queue and flush sequences.
module tb_lsq_mem_queue;
  import lsq_mem_queue_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ld_lsq = 1'b0, data_ready_in = 1'b0, cdb_grant = 1'b0, rob_commit = 1'b0, flush = 1'b0, mem_resp = 1'b0;
  lc3b_lsq_op op_in = LSQ_LDW;
  lc3b_rob_id dest_in = '0, qk_in = '0, rob_commit_pos = '0;
  lc3b_word vk_in = '0, mem_rdata = '0;
  lc3b_cdb agu_bus = '0, data_bus = '0;
  lc3b_cdb data_bus_out;
  logic lsq_available, cdb_req, mem_read, mem_write;
  lc3b_word mem_address, mem_wdata;
  logic [1:0] mem_byte_enable;
`ifdef LSQ_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_stall;
`endif
  int checks = 0;
  int failures = 0;

  lsq_mem_queue dut (
    .clk(clk), .reset_n(reset_n), .ld_lsq(ld_lsq), .op_in(op_in), .dest_in(dest_in), .vk_in(vk_in),
    .qk_in(qk_in), .data_ready_in(data_ready_in), .lsq_available(lsq_available), .agu_bus(agu_bus),
    .data_bus(data_bus), .data_bus_out(data_bus_out), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .rob_commit(rob_commit), .rob_commit_pos(rob_commit_pos), .flush(flush), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
`ifdef LSQ_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld; lc3b_lsq_op op; lc3b_rob_id dest, qk; lc3b_word vk; logic drdy;
    lc3b_rob_id ad; lc3b_word av; lc3b_rob_id dd; lc3b_word dv;
    logic commit; lc3b_rob_id cpos; logic resp; lc3b_word rdata; logic grant;
    logic e_avail, e_rd, e_wr, e_req; lc3b_word e_addr; logic [1:0] e_be; lc3b_word e_wdata;
    lc3b_rob_id e_bdest; lc3b_word e_bus;
  } vec_t;

  vec_t v [18];

  function automatic vec_t nv();
    vec_t r;
    r.ld = 1'b0; r.op = LSQ_LDW; r.dest = '0; r.qk = '0; r.vk = '0; r.drdy = 1'b0;
    r.ad = '0; r.av = '0; r.dd = '0; r.dv = '0; r.commit = 1'b0; r.cpos = '0;
    r.resp = 1'b0; r.rdata = '0; r.grant = 1'b0;
    r.e_avail = 1'b1; r.e_rd = 1'b0; r.e_wr = 1'b0; r.e_req = 1'b0;
    r.e_addr = '0; r.e_be = 2'b00; r.e_wdata = '0; r.e_bdest = '0; r.e_bus = '0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    ld_lsq = 1'b0; agu_bus = '0; data_bus = '0; rob_commit = 1'b0;
    mem_resp = 1'b0; cdb_grant = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic alloc(input lc3b_lsq_op op, input lc3b_rob_id d, input lc3b_word vk, input logic rdy);
    ld_lsq = 1'b1; op_in = op; dest_in = d; vk_in = vk; data_ready_in = rdy; qk_in = '0;
    step();
  endtask

  task automatic agu(input lc3b_rob_id d, input lc3b_word a);
    agu_bus.dest = d;
    agu_bus.value = a;
    step();
  endtask

  task automatic apply(input vec_t x);
    ld_lsq = x.ld; op_in = x.op; dest_in = x.dest; qk_in = x.qk; vk_in = x.vk; data_ready_in = x.drdy;
    agu_bus = '0; agu_bus.dest = x.ad; agu_bus.value = x.av;
    data_bus = '0; data_bus.dest = x.dd; data_bus.value = x.dv;
    rob_commit = x.commit; rob_commit_pos = x.cpos; mem_resp = x.resp; mem_rdata = x.rdata; cdb_grant = x.grant;
  endtask

  task automatic serve_load(input lc3b_rob_id d, input lc3b_word a, input lc3b_word rd, input logic exp_avail);
    int n = 0;
    #1;
    while (!mem_read && n < 20) begin
      step();
      #1;
      n++;
    end
    chk($sformatf("ld%0d issue", d), {15'd0, mem_read}, 16'd1);
    chk($sformatf("ld%0d addr", d), mem_address, a);
    mem_resp = 1'b1;
    mem_rdata = rd;
    step();
    cdb_grant = 1'b1;
    #1;
    chk($sformatf("ld%0d cdb_req", d), {15'd0, cdb_req}, 16'd1);
    chk($sformatf("ld%0d bus dest", d), {12'd0, data_bus_out.dest}, {12'd0, d});
    chk($sformatf("ld%0d bus value", d), data_bus_out.value, rd);
    chk($sformatf("ld%0d avail at pop", d), {15'd0, lsq_available}, {15'd0, exp_avail});
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    v[0] = nv();
    v[1] = nv(); v[1].ld = 1'b1; v[1].dest = 4'd3;
    v[2] = nv(); v[2].ad = 4'd3; v[2].av = 16'h3001;
    v[3] = nv(); v[3].e_rd = 1'b1; v[3].e_addr = 16'h3000; v[3].e_be = 2'b11;
    v[4] = nv(); v[4].resp = 1'b1; v[4].rdata = 16'hBEEF; v[4].e_rd = 1'b1; v[4].e_addr = 16'h3000; v[4].e_be = 2'b11;
    v[5] = nv(); v[5].grant = 1'b1; v[5].e_req = 1'b1; v[5].e_bdest = 4'd3; v[5].e_bus = 16'hBEEF;
    v[6] = nv();
    v[7] = nv(); v[7].ld = 1'b1; v[7].op = LSQ_LDB; v[7].dest = 4'd4;
    v[8] = nv(); v[8].ad = 4'd4; v[8].av = 16'h4001;
    v[9] = nv(); v[9].resp = 1'b1; v[9].rdata = 16'h80FF; v[9].e_rd = 1'b1; v[9].e_addr = 16'h4000;
    v[10] = nv(); v[10].e_req = 1'b1;
    v[11] = nv(); v[11].grant = 1'b1; v[11].e_req = 1'b1; v[11].e_bdest = 4'd4; v[11].e_bus = 16'hFF80;
    v[12] = nv(); v[12].ld = 1'b1; v[12].op = LSQ_STB; v[12].dest = 4'd5; v[12].qk = 4'd7;
    v[13] = nv(); v[13].ad = 4'd5; v[13].av = 16'h2000; v[13].dd = 4'd7; v[13].dv = 16'h12AB;
    v[14] = nv(); v[14].commit = 1'b1; v[14].cpos = 4'd5;
    v[15] = nv(); v[15].e_wr = 1'b1; v[15].e_addr = 16'h2000; v[15].e_be = 2'b01; v[15].e_wdata = 16'hABAB;
    v[16] = nv(); v[16].resp = 1'b1; v[16].e_wr = 1'b1; v[16].e_addr = 16'h2000; v[16].e_be = 2'b01; v[16].e_wdata = 16'hABAB;
    v[17] = nv();

    #2;
    chk("reset mem_read", {15'd0, mem_read}, 16'd0);
    chk("reset mem_write", {15'd0, mem_write}, 16'd0);
    chk("reset cdb_req", {15'd0, cdb_req}, 16'd0);
    chk("reset mem_address", mem_address, 16'h0000);
    chk("reset avail", {15'd0, lsq_available}, 16'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply(v[i]);
      #1;
      chk($sformatf("v%0d avail", i), {15'd0, lsq_available}, {15'd0, v[i].e_avail});
      chk($sformatf("v%0d mem_read", i), {15'd0, mem_read}, {15'd0, v[i].e_rd});
      chk($sformatf("v%0d mem_write", i), {15'd0, mem_write}, {15'd0, v[i].e_wr});
      chk($sformatf("v%0d cdb_req", i), {15'd0, cdb_req}, {15'd0, v[i].e_req});
      if (v[i].e_rd || v[i].e_wr) chk($sformatf("v%0d mem_address", i), mem_address, v[i].e_addr);
      if (v[i].e_be != 2'b00) chk($sformatf("v%0d byte_enable", i), {14'd0, mem_byte_enable}, {14'd0, v[i].e_be});
      if (v[i].e_wr) chk($sformatf("v%0d mem_wdata", i), mem_wdata, v[i].e_wdata);
      if (v[i].e_req && v[i].grant) begin
        chk($sformatf("v%0d bus dest", i), {12'd0, data_bus_out.dest}, {12'd0, v[i].e_bdest});
        chk($sformatf("v%0d bus value", i), data_bus_out.value, v[i].e_bus);
      end
      @(posedge clk);
      #1;
    end
    idle();

    // full queue, ignored dispatch, pop not freeing same cycle, tail wrap to slot 0
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      ld_lsq = 1'b1; op_in = LSQ_LDW; dest_in = lc3b_rob_id'(i); data_ready_in = 1'b0;
      #1;
      chk($sformatf("fill%0d avail", i), {15'd0, lsq_available}, 16'd1);
      step();
    end
    #1;
    chk("full avail", {15'd0, lsq_available}, 16'd0);
    ld_lsq = 1'b1; op_in = LSQ_LDW; dest_in = 4'd9;
    step();
    #1;
    chk("full after ignored ld avail", {15'd0, lsq_available}, 16'd0);
    for (int i = 1; i <= 8; i++) agu(lc3b_rob_id'(i), 16'(i) << 8);
    serve_load(4'd1, 16'h0100, 16'h1001, 1'b0);
    #1;
    chk("avail after pop", {15'd0, lsq_available}, 16'd1);
    alloc(LSQ_LDW, 4'd10, 16'h0000, 1'b0);
    #1;
    chk("refilled avail", {15'd0, lsq_available}, 16'd0);
    agu(4'd10, 16'h0A00);
    for (int i = 2; i <= 8; i++) serve_load(lc3b_rob_id'(i), 16'(i) << 8, 16'h1000 + 16'(i), i != 2);
    serve_load(4'd10, 16'h0A00, 16'h100A, 1'b1);
    agu(4'd9, 16'h0900);
    step();
    #1;
    chk("drained mem_read", {15'd0, mem_read}, 16'd0);
    chk("drained avail", {15'd0, lsq_available}, 16'd1);

    // flush while a load is outstanding, with a same-cycle dispatch that must be dropped
    do_reset();
    alloc(LSQ_LDW, 4'd1, 16'h0000, 1'b0);
    alloc(LSQ_LDW, 4'd2, 16'h0000, 1'b0);
    alloc(LSQ_STW, 4'd3, 16'h0005, 1'b1);
    agu(4'd1, 16'h0500);
    #1;
    chk("fl_load issue", {15'd0, mem_read}, 16'd1);
    agu(4'd2, 16'h0600);
    flush = 1'b1; ld_lsq = 1'b1; op_in = LSQ_LDW; dest_in = 4'd6;
    #1;
    chk("fl_load read in flush", {15'd0, mem_read}, 16'd1);
    step();
    #1;
    chk("drop read held", {15'd0, mem_read}, 16'd1);
    chk("drop address", mem_address, 16'h0500);
    chk("drop no cdb_req", {15'd0, cdb_req}, 16'd0);
    step();
    #1;
    chk("drop read held 2", {15'd0, mem_read}, 16'd1);
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    step();
    #1;
    chk("after drop read", {15'd0, mem_read}, 16'd0);
    chk("after drop cdb_req", {15'd0, cdb_req}, 16'd0);
    agu(4'd6, 16'h0700);
    agu(4'd2, 16'h0600);
    step();
    #1;
    chk("flushed queue idle read", {15'd0, mem_read}, 16'd0);
    chk("flushed queue cdb_req", {15'd0, cdb_req}, 16'd0);

    // flush while a committed store is in flight
    do_reset();
    alloc(LSQ_STW, 4'd1, 16'h1234, 1'b1);
    alloc(LSQ_LDW, 4'd2, 16'h0000, 1'b0);
    alloc(LSQ_LDW, 4'd3, 16'h0000, 1'b0);
    agu(4'd2, 16'h0900);
    agu(4'd3, 16'h0A00);
    rob_commit = 1'b1; rob_commit_pos = 4'd1;
    agu(4'd1, 16'h0800);
    #1;
    chk("st issue write", {15'd0, mem_write}, 16'd1);
    chk("st address", mem_address, 16'h0800);
    chk("st wdata", mem_wdata, 16'h1234);
    chk("st byte_enable", {14'd0, mem_byte_enable}, 16'd3);
    step();
    flush = 1'b1;
    #1;
    chk("st write in flush", {15'd0, mem_write}, 16'd1);
    step();
    #1;
    chk("st continues", {15'd0, mem_write}, 16'd1);
    mem_resp = 1'b1;
    step();
    #1;
    chk("st done write", {15'd0, mem_write}, 16'd0);
    chk("st younger loads gone", {15'd0, mem_read}, 16'd0);
    step();
    #1;
    chk("st younger loads gone 2", {15'd0, mem_read}, 16'd0);
    alloc(LSQ_LDW, 4'd4, 16'h0000, 1'b0);
    agu(4'd4, 16'h0B00);
    serve_load(4'd4, 16'h0B00, 16'h4444, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsq_mem_queue.md
# lsq_mem_queue

In-order load/store queue downstream of the AGU reservation stations in the LC-3b Tomasulo core. Memory ops are allocated here at dispatch in program order. Effective addresses are captured from the AGU output bus, and store data is snooped from the CDB. Accesses are issued one at a time from the head to the data-memory port, and load results are broadcast on the CDB under arbiter grant.

## Interface
- DEPTH, 8, number of queue entries (power of two, ≥2)
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- ld_lsq  in  1  allocate entry at tail (ignored when lsq_available=0)
- op_in  in  lc3b_lsq_op  LDW/LDB/STW/STB
- dest_in  in  lc3b_rob_id  ROB id of the instruction
- vk_in  in  lc3b_word  store data, if ready
- qk_in  in  lc3b_rob_id  store-data producer tag
- data_ready_in  in  1  vk_in valid at dispatch
- lsq_available  out  1  count < DEPTH
- agu_bus  in  lc3b_cdb  AGU result bus (dest = ROB id, value = address)
- data_bus  in  lc3b_cdb  common data bus (snooped)
- data_bus_out  out  lc3b_cdb  load-result drive, Z unless granted
- cdb_req  out  1  load result pending
- cdb_grant  in  1  arbiter grant for this cycle
- rob_commit  in  1  ROB commit strobe
- rob_commit_pos  in  lc3b_rob_id  committing ROB id
- flush  in  1  squash uncommitted entries
- mem_address  out  lc3b_word
- mem_read, mem_write  out  1
- mem_wdata  out  lc3b_word
- mem_byte_enable  out  2
- mem_resp  in  1
- mem_rdata  in  lc3b_word

## Operation
- **Entry fields:** valid, op, dest, addr, addr_v, data, data_v, data_tag, committed.
- **Queue bookkeeping:** circular buffer with head, tail and count. Pointers wrap modulo DEPTH.
- **Address capture:** any valid entry with addr_v=0 whose dest equals agu_bus.dest while agu_bus.dest ≠ 0 latches the address.
- **Store-data capture:** any store entry with data_v=0 whose data_tag equals data_bus.dest latches data_bus.value.
- **Commit marking:** rob_commit with rob_commit_pos equal to an entry's dest sets committed. Only stores use this flag.
- **FSM states:** IDLE, LOAD, STORE, WAIT_CDB, DROP.
- **IDLE:**
  - Go to LOAD if the head is a valid load with addr_v.
  - Go to STORE if the head is a valid store with addr_v, data_v and committed.
- **LOAD:** mem_read=1 until mem_resp. On mem_resp, latch the formatted result and go to WAIT_CDB.
- **STORE:** mem_write=1 until mem_resp. On mem_resp, pop the head and go to IDLE.
- **WAIT_CDB:** cdb_req=1. While cdb_grant=1, drive data_bus_out.dest=head.dest, data_bus_out.value=result, update_pc=0, update_pc_value=0, ready=0. Pop the head at the edge and go to IDLE.
- **Word ops:** mem_address = addr & 0xFFFE, mem_byte_enable=11.
- **Byte ops:** mem_address = addr & 0xFFFE.
  - LDB result is the byte selected by addr[0], sign-extended to 16 bits.
  - STB mem_wdata = {data[7:0], data[7:0]}, mem_byte_enable = addr[0] ? 10 : 01.
- **Flush:** invalidate every entry with committed=0. The tail and count retract to the committed prefix at the head.
  - In LOAD, go to DROP. DROP keeps mem_read asserted until mem_resp, then returns to IDLE and discards the data.
  - In WAIT_CDB, go to IDLE, discard the result and deassert cdb_req the same cycle.
  - In STORE, the access continues; the head is committed and survives.
- **Reset:** all entries invalid, pointers and count 0, state IDLE. All memory and request outputs are 0 and data_bus_out is Z.

## Timing
- Allocation is written at the edge ending the ld_lsq cycle.
- Captures on agu_bus and data_bus are usable from the next cycle. A same-cycle AGU broadcast to the entry being allocated is not captured.
- If addr_v is set at edge E, mem_read is asserted in the cycle after E.
- mem_resp in cycle M gives cdb_req=1 in M+1. The earliest pop is at the end of M+1.
- lsq_available reflects the registered count. A same-cycle pop does not free a slot for dispatch.
- Flush and ld_lsq in the same cycle: flush wins and no allocation occurs.
- A pop and an allocation in the same cycle leave count unchanged.
- mem_* outputs are combinational from the state and head entry, and are stable while waiting for mem_resp.

## Configuration
- LSQ_STATS_EN defined adds three outputs, each 16 bits, saturating at 0xFFFF, reset to 0:
  - stat_loads counts retired loads.
  - stat_stores counts retired stores.
  - stat_stall counts cycles where the head is valid and the state is IDLE but no issue occurs.
- LSQ_STATS_EN undefined: the ports and counters are absent.

## Structure
- Add to lc3b_types: lc3b_lsq_entry struct, lc3b_lsq_op enum (shared with the AGU), and the LSQ FSM state enum.
- Add to macros.sv: `NUM_LSQ_ENTRIES`.
- Sub-module lsq_mem_format, combinational: mem_address, mem_byte_enable, mem_wdata and the load sign-extension.

## Test plan
- **LDW:** dispatch LDW dest=3; agu_bus {3, 0x3001} next cycle -> mem_address=0x3000, be=11; mem_rdata=0xBEEF -> cdb_req; grant -> data_bus_out {3, 0xBEEF}; count=0.
- **LDB sign-extend:** LDB at 0x4001, mem_rdata=0x80FF -> result 0xFF80.
- **STB:** STB dest=5, data tag 7; CDB {7, 0x12AB}, address 0x2000, commit pos 5 -> mem_write, wdata=0xABAB, be=01.
- **Full queue:** fill DEPTH entries -> lsq_available=0; ld_lsq ignored; one pop -> available=1 next cycle; tail wraps to index 0.
- **Flush in LOAD:** flush during LOAD with two younger entries -> DROP, mem_read held until mem_resp, no cdb_req, queue empty afterwards.
- **Flush in STORE:** flush while a committed store is in STORE -> store completes, only uncommitted entries removed.
